// File: rtl/trex_game_core.sv
// Runner-game control core: run/pause/dead FSM, multi-life collision handling,
// score/high-score counters and registered RGB332 compositor. Optional night palette: TREX_NIGHT_MODE_EN.
module trex_game_core #(
  parameter int NUM_OBS       = 2,
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int SCORE_W       = 14,
  parameter int SCREEN_W      = 640,
  parameter int SCREEN_H      = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_ce,
  input  logic               frame_tick,
  input  logic               score_tick,
  input  logic               jump,
  input  logic               restart,
  input  logic               pause,
  input  logic [9:0]         vga_x,
  input  logic [8:0]         vga_y,
  input  logic               dino_grey,
  input  logic               dino_white,
  input  logic               bg_grey,
  input  logic               score_grey,
  input  logic [NUM_OBS-1:0] obs_grey,
  input  logic [NUM_OBS-1:0] obs_white,
  output logic [7:0]         rgb,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hi_score,
  output logic [3:0]         lives_left,
  output logic [NUM_OBS-1:0] hit_mask,
  output logic               invuln
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b10,
    ST_DEAD  = 2'b01,
    ST_PAUSE = 2'b11
  } state_t;

  localparam logic [9:0]         SCR_W      = 10'(SCREEN_W);
  localparam logic [8:0]         SCR_H      = 9'(SCREEN_H);
  localparam logic [3:0]         LIVES_INIT = 4'(LIVES);
  localparam logic [7:0]         INV_INIT   = 8'(INVULN_FRAMES);
  localparam logic [SCORE_W-1:0] SCORE_ONE  = {{(SCORE_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic                 pause_prev_q;
  logic [NUM_OBS-1:0]   pending_q, pending_d;
  logic [NUM_OBS-1:0]   hit_mask_q, hit_mask_d;
  logic [3:0]           lives_q, lives_d;
  logic                 invuln_q, invuln_d;
  logic [7:0]           inv_cnt_q, inv_cnt_d;
  logic [SCORE_W-1:0]   score_q, score_d, score_plus;
  logic [SCORE_W-1:0]   hi_score_q, hi_score_d;
  logic [7:0]           rgb_q, rgb_d;
  logic                 night_q;

  logic                 visible, sample_en, pause_rise, score_inc, restart_clr;
  logic                 any_white, any_grey;
  logic [7:0]           comp;
  logic [NUM_OBS-1:0]   sample, hits;

  always_comb begin
    visible     = (vga_x != 10'd0) && (vga_x <= SCR_W) && (vga_y != 9'd0) && (vga_y <= SCR_H);
    sample_en   = pix_ce && (state_q == ST_RUN) && !invuln_q && visible;
    sample      = sample_en ? (obs_grey & {NUM_OBS{dino_grey}}) : '0;
    hits        = pending_q | sample;
    pause_rise  = pause && !pause_prev_q;
    score_plus  = score_q + SCORE_ONE;
    score_inc   = score_tick && (state_q == ST_RUN) && (score_q != '1);
    restart_clr = (state_q == ST_DEAD) && restart;
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    hit_mask_d = hit_mask_q;
    lives_d    = lives_q;
    invuln_d   = invuln_q;
    inv_cnt_d  = inv_cnt_q;
    score_d    = score_inc ? score_plus : score_q;
    hi_score_d = hi_score_q;

    case (state_q)
      ST_IDLE: if (jump) state_d = ST_RUN;
      ST_RUN: begin
        if (pause_rise) begin
          // A pause edge pre-empts any frame evaluation on the same cycle.
          state_d = ST_PAUSE;
        end else if (frame_tick) begin
          if (hits != '0) begin
            hit_mask_d = hits;
            lives_d    = lives_q - 4'd1;
            pending_d  = '0;
            if (lives_d == 4'd0) begin
              state_d = ST_DEAD;
            end else begin
              invuln_d  = 1'b1;
              inv_cnt_d = INV_INIT;
            end
          end else begin
            hit_mask_d = '0;
            if (invuln_q) begin
              inv_cnt_d = inv_cnt_q - 8'd1;
              if (inv_cnt_d == 8'd0) invuln_d = 1'b0;
            end
          end
        end else begin
          pending_d = pending_q | sample;
        end
      end
      ST_PAUSE: if (pause_rise) state_d = ST_RUN;
      ST_DEAD: begin
        // score is frozen in DEAD, so comparing on every DEAD cycle equals comparing once on entry.
        if (score_q > hi_score_q) hi_score_d = score_q;
        if (restart) begin
          state_d    = ST_IDLE;
          score_d    = '0;
          hit_mask_d = '0;
          pending_d  = '0;
          invuln_d   = 1'b0;
          inv_cnt_d  = 8'd0;
          lives_d    = LIVES_INIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    any_white = dino_white || (|obs_white);
    any_grey  = dino_grey || bg_grey || score_grey || (|obs_grey);
    if (any_white)     comp = 8'hFF;
    else if (any_grey) comp = 8'h00;
    else if (visible)  comp = 8'hFF;
    else               comp = 8'h00;
    rgb_d = rgb_q;
    if (pix_ce) rgb_d = night_q ? ~comp : comp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pause_prev_q <= 1'b0;
      pending_q    <= '0;
      hit_mask_q   <= '0;
      lives_q      <= LIVES_INIT;
      invuln_q     <= 1'b0;
      inv_cnt_q    <= 8'd0;
      score_q      <= '0;
      hi_score_q   <= '0;
      rgb_q        <= 8'h00;
    end else begin
      state_q      <= state_d;
      pause_prev_q <= pause;
      pending_q    <= pending_d;
      hit_mask_q   <= hit_mask_d;
      lives_q      <= lives_d;
      invuln_q     <= invuln_d;
      inv_cnt_q    <= inv_cnt_d;
      score_q      <= score_d;
      hi_score_q   <= hi_score_d;
      rgb_q        <= rgb_d;
    end
  end

`ifdef TREX_NIGHT_MODE_EN
  logic night_d;

  // Flip the palette each time the score crosses a nonzero multiple of 512.
  always_comb begin
    night_d = night_q;
    if (score_inc && (score_plus[8:0] == 9'd0) && (score_plus != '0)) night_d = ~night_q;
    if (restart_clr) night_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) night_q <= 1'b0;
    else     night_q <= night_d;
  end
`else
  assign night_q = 1'b0;
`endif

  assign rgb        = rgb_q;
  assign state      = state_q;
  assign score      = score_q;
  assign hi_score   = hi_score_q;
  assign lives_left = lives_q;
  assign hit_mask   = hit_mask_q;
  assign invuln     = invuln_q;

endmodule

// File: tb/tb_trex_game_core.sv
// Directed self-checking bench for trex_game_core with default parameters.
module tb_trex_game_core;

  logic        clk = 1'b0;
  logic        rst, pix_ce, frame_tick, score_tick, jump, restart, pause;
  logic [9:0]  vga_x;
  logic [8:0]  vga_y;
  logic        dino_grey, dino_white, bg_grey, score_grey;
  logic [1:0]  obs_grey, obs_white;
  logic [7:0]  rgb;
  logic [1:0]  state;
  logic [13:0] score, hi_score;
  logic [3:0]  lives_left;
  logic [1:0]  hit_mask;
  logic        invuln;

  int n_checks = 0;
  int n_fail   = 0;

  trex_game_core dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .frame_tick(frame_tick), .score_tick(score_tick),
    .jump(jump), .restart(restart), .pause(pause), .vga_x(vga_x), .vga_y(vga_y),
    .dino_grey(dino_grey), .dino_white(dino_white), .bg_grey(bg_grey), .score_grey(score_grey),
    .obs_grey(obs_grey), .obs_white(obs_white), .rgb(rgb), .state(state), .score(score),
    .hi_score(hi_score), .lives_left(lives_left), .hit_mask(hit_mask), .invuln(invuln)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_flags();
    dino_grey = 0; dino_white = 0; bg_grey = 0; score_grey = 0;
    obs_grey = 2'b00; obs_white = 2'b00;
  endtask

  // One frame: an optional dino/obstacle overlap on a visible strobe, then a frame_tick.
  task automatic frame(input logic [1:0] overlap);
    vga_x = 10'd100; vga_y = 9'd100;
    pix_ce = 1; dino_grey = (overlap != 2'b00); obs_grey = overlap;
    cyc();
    pix_ce = 0; clear_flags();
    frame_tick = 1;
    cyc();
    frame_tick = 0;
  endtask

  task automatic pixel(input logic [9:0] x, input logic [8:0] y);
    vga_x = x; vga_y = y; pix_ce = 1;
    cyc();
    pix_ce = 0;
  endtask

  initial begin
    rst = 1; pix_ce = 0; frame_tick = 0; score_tick = 0; jump = 0; restart = 0; pause = 0;
    vga_x = 0; vga_y = 0; clear_flags();
    cyc(); cyc();
    rst = 0;
    cyc();
    check("reset_state", state, 2'b00);
    check("reset_rgb", rgb, 8'h00);
    check("reset_score", score, 0);
    check("reset_hi", hi_score, 0);
    check("reset_lives", lives_left, 3);
    check("reset_hitmask", hit_mask, 0);
    check("reset_invuln", invuln, 0);

    // Start and score
    jump = 1; cyc(); jump = 0;
    check("start_run", state, 2'b10);
    score_tick = 1;
    for (int i = 0; i < 25; i++) cyc();
    score_tick = 0;
    check("score_25", score, 25);
    check("lives_3", lives_left, 3);

    restart = 1; cyc(); restart = 0;
    check("restart_ignored_run", state, 2'b10);
    check("restart_ignored_score", score, 25);

    // Non-fatal hit on channel 1, then 60 immune frames with overlaps
    frame(2'b10);
    check("hit1_mask", hit_mask, 2'b10);
    check("hit1_lives", lives_left, 2);
    check("hit1_invuln", invuln, 1);
    for (int i = 0; i < 59; i++) frame(2'b11);
    check("immune59_invuln", invuln, 1);
    check("immune59_lives", lives_left, 2);
    check("immune59_mask", hit_mask, 0);
    frame(2'b11);
    check("immune60_invuln", invuln, 0);
    check("immune60_lives", lives_left, 2);

    // Pending hit, then pause edge coinciding with frame_tick: no evaluation
    vga_x = 10'd100; vga_y = 9'd100; pix_ce = 1; dino_grey = 1; obs_grey = 2'b10;
    cyc();
    pix_ce = 0; clear_flags();
    pause = 1; frame_tick = 1; cyc(); frame_tick = 0;
    check("pause_state", state, 2'b11);
    check("pause_no_eval_lives", lives_left, 2);
    score_tick = 1; frame_tick = 1;
    for (int i = 0; i < 5; i++) cyc();
    score_tick = 0; frame_tick = 0;
    check("pause_score_frozen", score, 25);
    check("pause_lives_frozen", lives_left, 2);
    check("pause_mask_frozen", hit_mask, 0);
    pause = 0; cyc();
    check("pause_hold", state, 2'b11);
    pause = 1; cyc();
    check("resume_state", state, 2'b10);
    pause = 0;
    // The pending overlap from before the pause is evaluated now
    frame_tick = 1; cyc(); frame_tick = 0;
    check("hit2_mask", hit_mask, 2'b10);
    check("hit2_lives", lives_left, 1);
    check("hit2_invuln", invuln, 1);
    for (int i = 0; i < 60; i++) frame(2'b00);
    check("hit2_clear_invuln", invuln, 0);

    // Fatal hit: sample, frame_tick and score_tick on the same cycle
    vga_x = 10'd100; vga_y = 9'd100; pix_ce = 1; dino_grey = 1; obs_grey = 2'b01;
    frame_tick = 1; score_tick = 1;
    cyc();
    pix_ce = 0; frame_tick = 0; score_tick = 0; clear_flags();
    check("dead_state", state, 2'b01);
    check("dead_lives", lives_left, 0);
    check("dead_mask", hit_mask, 2'b01);
    check("dead_score", score, 26);
    cyc();
    check("dead_hi", hi_score, 26);
    restart = 1; cyc(); restart = 0;
    check("restart_state", state, 2'b00);
    check("restart_score", score, 0);
    check("restart_lives", lives_left, 3);
    check("restart_hi_kept", hi_score, 26);
    check("restart_mask", hit_mask, 0);

    // Compositor
    dino_white = 1; dino_grey = 1; pixel(10'd100, 9'd100);
    check("comp_white_grey", rgb, 8'hFF);
    clear_flags(); bg_grey = 1; cyc();
    check("comp_hold", rgb, 8'hFF);
    pixel(10'd100, 9'd100);
    check("comp_grey", rgb, 8'h00);
    clear_flags(); pixel(10'd100, 9'd100);
    check("comp_visible", rgb, 8'hFF);
    pixel(10'd700, 9'd10);
    check("comp_outside", rgb, 8'h00);
    cyc();
    check("comp_hold_outside", rgb, 8'h00);
    obs_white = 2'b10; pixel(10'd700, 9'd10);
    check("comp_obs_white", rgb, 8'hFF);
    clear_flags(); pixel(10'd0, 9'd100);
    check("comp_x0", rgb, 8'h00);
    pixel(10'd640, 9'd480);
    check("comp_corner", rgb, 8'hFF);
    pixel(10'd641, 9'd100);
    check("comp_x641", rgb, 8'h00);

    // Jump and pause edge together: pause consumed
    jump = 1; pause = 1; cyc(); jump = 0;
    cyc();
    check("jump_pause_run", state, 2'b10);
    pause = 0;

    // Night mode at score 512
    score_tick = 1;
    for (int i = 0; i < 512; i++) cyc();
    score_tick = 0;
    check("score_512", score, 512);
    pixel(10'd100, 9'd100);
`ifdef TREX_NIGHT_MODE_EN
    check("night_bg", rgb, 8'h00);
`else
    check("night_bg", rgb, 8'hFF);
`endif

    // Saturation
    score_tick = 1;
    for (int i = 0; i < 16383 - 512 + 3; i++) cyc();
    score_tick = 0;
    check("score_saturate", score, 16383);

    // Reset mid-game
    rst = 1; cyc(); rst = 0;
    check("rst_state", state, 2'b00);
    check("rst_score", score, 0);
    check("rst_hi", hi_score, 0);
    check("rst_lives", lives_left, 3);
    check("rst_rgb", rgb, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
